// File: rtl/fetch_sequencer_pkg.sv
// Shared ISA definitions for the 8-bit core: halt opcode, sequencer states,
// program-select encodings and default resident-program base addresses.
package fetch_sequencer_pkg;

  localparam logic [7:0] HALT_OP = 8'b1000_1000;

  localparam logic [7:0] DEF_PROG0_BASE = 8'd0;    // multiply
  localparam logic [7:0] DEF_PROG1_BASE = 8'd100;  // string match
  localparam logic [7:0] DEF_PROG2_BASE = 8'd150;  // closest pair

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    SEL_PROG0 = 2'd0,
    SEL_PROG1 = 2'd1,
    SEL_PROG2 = 2'd2,
    SEL_RSVD  = 2'd3
  } prog_sel_e;

endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Combinational next-PC: sequential advance or register-relative branch,
// all arithmetic modulo 256.
module pc_next_calc (
  input  logic [7:0] pc,
  input  logic       branch_i,
  input  logic       branch_back_i,
  input  logic [7:0] offset_i,
  output logic [7:0] pc_next
);

  logic [7:0] pc_inc;

  assign pc_inc = pc + 8'd1;

  // Branch distance is relative to the instruction after the branch.
  always_comb begin
    pc_next = pc_inc;
    if (branch_i) begin
      if (branch_back_i) pc_next = pc_inc - offset_i;
      else               pc_next = pc_inc + offset_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC feeding the combinational instruction ROM,
// runs the IDLE/RUN/HALTED control FSM and counts retired instructions.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [7:0]  PROG0_BASE = DEF_PROG0_BASE,
  parameter logic [7:0]  PROG1_BASE = DEF_PROG1_BASE,
  parameter logic [7:0]  PROG2_BASE = DEF_PROG2_BASE,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       prog_sel_i,
  input  logic             abort_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             branch_back_i,
  input  logic [7:0]       offset_i,
  input  logic [7:0]       inst_i,
  output logic [7:0]       address_o,
  output logic             inst_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             bad_sel_o,
  output logic [CNT_W-1:0] retired_o
);

  seq_state_e       state;
  logic [7:0]       pc;
  logic [7:0]       pc_next;
  logic [7:0]       base;
  logic [CNT_W-1:0] retired;
  logic             bad_sel;

  pc_next_calc u_pc_next_calc (
    .pc            (pc),
    .branch_i      (branch_i),
    .branch_back_i (branch_back_i),
    .offset_i      (offset_i),
    .pc_next       (pc_next)
  );

  // Start address of the selected resident program.
  always_comb begin
    base = PROG0_BASE;
    case (prog_sel_i)
      SEL_PROG1: base = PROG1_BASE;
      SEL_PROG2: base = PROG2_BASE;
      default:   base = PROG0_BASE;
    endcase
  end

  // Control FSM, PC register, retired counter and bad-select pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      retired <= '0;
      bad_sel <= 1'b0;
    end else begin
      bad_sel <= 1'b0;
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (abort_i) begin
            state <= ST_IDLE;
            pc    <= '0;
          end else if (start_i) begin
            if (prog_sel_i == SEL_RSVD) begin
              bad_sel <= 1'b1;
            end else begin
              pc      <= base;
              retired <= '0;
              state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state <= ST_IDLE;
            pc    <= '0;
          end else if (!stall_i) begin
            if (retired != '1) retired <= retired + CNT_W'(1);
            // Halt retires but leaves the PC parked on its own address.
            if (inst_i == HALT_OP) state <= ST_HALTED;
            else                   pc    <= pc_next;
          end
        end
        default: begin
          state <= ST_IDLE;
          pc    <= '0;
        end
      endcase
    end
  end

  assign address_o    = pc;
  assign busy_o       = (state == ST_RUN);
  assign inst_valid_o = (state == ST_RUN);
  assign done_o       = (state == ST_HALTED);
  assign bad_sel_o    = bad_sel;
  assign retired_o    = retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each step pushes the expected
// post-edge outputs to a scoreboard and pops/compares them after the edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  prog_sel_i;
  logic        abort_i;
  logic        stall_i;
  logic        branch_i;
  logic        branch_back_i;
  logic [7:0]  offset_i;
  logic [7:0]  inst_i;
  logic [7:0]  address_o;
  logic        inst_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        bad_sel_o;
  logic [15:0] retired_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [7:0]  addr;
    logic [15:0] ret;
    logic        busy;
    logic        done;
    logic        bad;
  } exp_t;

  exp_t sb[$];

  fetch_sequencer #(
    .PROG0_BASE (8'd0),
    .PROG1_BASE (8'd100),
    .PROG2_BASE (8'd150),
    .CNT_W      (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .prog_sel_i    (prog_sel_i),
    .abort_i       (abort_i),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .branch_back_i (branch_back_i),
    .offset_i      (offset_i),
    .inst_i        (inst_i),
    .address_o     (address_o),
    .inst_valid_o  (inst_valid_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .bad_sel_o     (bad_sel_o),
    .retired_o     (retired_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] a, input logic [15:0] r,
                      input logic b, input logic d, input logic bs);
    exp_t e;
    e.tag = tag; e.addr = a; e.ret = r; e.busy = b; e.done = d; e.bad = bs;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".addr"},  32'(address_o),    32'(e.addr));
    chk({e.tag, ".ret"},   32'(retired_o),    32'(e.ret));
    chk({e.tag, ".busy"},  32'(busy_o),       32'(e.busy));
    chk({e.tag, ".valid"}, 32'(inst_valid_o), 32'(e.busy));
    chk({e.tag, ".done"},  32'(done_o),       32'(e.done));
    chk({e.tag, ".bad"},   32'(bad_sel_o),    32'(e.bad));
  endtask

  // One clock: expectation queued with the stimulus, compared after the edge.
  task automatic step(input string tag, input logic [7:0] a, input logic [15:0] r,
                      input logic b, input logic d, input logic bs);
    push(tag, a, r, b, d, bs);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic idle_inputs();
    start_i = 0; prog_sel_i = 0; abort_i = 0; stall_i = 0;
    branch_i = 0; branch_back_i = 0; offset_i = 0; inst_i = 8'h00;
  endtask

  task automatic br(input logic back, input logic [7:0] off);
    idle_inputs();
    branch_i = 1; branch_back_i = back; offset_i = off;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle_inputs();
    step("reset", 8'd0, 16'd0, 0, 0, 0);
    reset = 0;

    // Program 1, straight-line code; start in RUN is ignored.
    start_i = 1; prog_sel_i = 1;
    step("start_p1", 8'd100, 16'd0, 1, 0, 0);
    idle_inputs();
    step("seq1", 8'd101, 16'd1, 1, 0, 0);
    start_i = 1; prog_sel_i = 2;
    step("seq2_start_ignored", 8'd102, 16'd2, 1, 0, 0);
    idle_inputs();
    step("seq3", 8'd103, 16'd3, 1, 0, 0);

    // Abort in RUN: IDLE, PC 0, count held.
    abort_i = 1;
    step("abort_run", 8'd0, 16'd3, 0, 0, 0);

    // Program 0 and branch arithmetic.
    idle_inputs(); start_i = 1; prog_sel_i = 0;
    step("start_p0", 8'd0, 16'd0, 1, 0, 0);
    br(0, 8'd16);  step("fwd_to17", 8'd17, 16'd1, 1, 0, 0);
    br(0, 8'd8);   step("fwd17_8", 8'd26, 16'd2, 1, 0, 0);
    br(0, 8'd22);  step("fwd_to49", 8'd49, 16'd3, 1, 0, 0);
    br(1, 8'd38);  step("back49_38", 8'd12, 16'd4, 1, 0, 0);
    br(0, 8'd47);  step("fwd_to60", 8'd60, 16'd5, 1, 0, 0);

    // Stall beats branch and holds PC and count.
    br(0, 8'd47); stall_i = 1;
    step("stall1", 8'd60, 16'd5, 1, 0, 0);
    step("stall2", 8'd60, 16'd5, 1, 0, 0);
    step("stall3", 8'd60, 16'd5, 1, 0, 0);

    br(0, 8'd189); step("fwd_to250", 8'd250, 16'd6, 1, 0, 0);
    br(0, 8'd10);  step("fwd_wrap", 8'd5, 16'd7, 1, 0, 0);
    br(1, 8'd10);  step("back_wrap", 8'd252, 16'd8, 1, 0, 0);
    br(0, 8'd102); step("fwd_to99", 8'd99, 16'd9, 1, 0, 0);

    // Halt with branch asserted: halt wins, counted, PC parked.
    br(0, 8'd5); inst_i = 8'h88;
    step("halt", 8'd99, 16'd10, 0, 1, 0);
    idle_inputs();
    step("halted_hold", 8'd99, 16'd10, 0, 1, 0);

    start_i = 1; prog_sel_i = 3;
    step("badsel_halted", 8'd99, 16'd10, 0, 1, 1);
    idle_inputs();
    step("badsel_clear", 8'd99, 16'd10, 0, 1, 0);

    start_i = 1; prog_sel_i = 2;
    step("start_p2", 8'd150, 16'd0, 1, 0, 0);
    idle_inputs();
    step("p2_seq", 8'd151, 16'd1, 1, 0, 0);
    inst_i = 8'h88;
    step("halt2", 8'd151, 16'd2, 0, 1, 0);

    // Abort from HALTED; abort beats start in IDLE; reserved select in IDLE.
    idle_inputs(); abort_i = 1;
    step("abort_halted", 8'd0, 16'd2, 0, 0, 0);
    start_i = 1; prog_sel_i = 0;
    step("abort_beats_start", 8'd0, 16'd2, 0, 0, 0);
    idle_inputs(); start_i = 1; prog_sel_i = 3;
    step("badsel_idle", 8'd0, 16'd2, 0, 0, 1);
    idle_inputs();
    step("badsel_idle_clear", 8'd0, 16'd2, 0, 0, 0);

    // 255 + 1 wraps to 0.
    start_i = 1; prog_sel_i = 0;
    step("start_p0b", 8'd0, 16'd0, 1, 0, 0);
    br(0, 8'd254); step("fwd_to255", 8'd255, 16'd1, 1, 0, 0);
    idle_inputs(); step("inc_wrap", 8'd0, 16'd2, 1, 0, 0);

    // Asynchronous reset mid-RUN at PC 37.
    br(0, 8'd36); step("fwd_to37", 8'd37, 16'd3, 1, 0, 0);
    idle_inputs();
    #2;
    reset = 1;
    push("async_reset", 8'd0, 16'd0, 0, 0, 0);
    #1;
    check_front();
    @(posedge clk); #1;
    reset = 0;
    step("post_reset_idle", 8'd0, 16'd0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
